nand_dq_delay_cal: RTL and testbench

Read-capture calibration controller for one NAND DQ byte lane. It sweeps the shared IDELAYE2 tap setting of the lane's DQ input-delay elements from 0 to TAP_MAX and checks captured training beats against a fixed pattern at each tap. It then finds the longest passing window and parks the delay at the window centre. The block sits between the NAND controller's init/training sequencer and the per-bit DQ IOB instances, and owns their dlyce/dlyinc/dlyrst inputs.

---
 rtl/nand_phy_pkg.sv | 24 ++
 rtl/nand_dq_eye_track.sv | 80 ++++++++
 rtl/nand_dq_delay_cal.sv | 188 ++++++++++++++++++
 tb/tb_nand_dq_delay_cal.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_phy_pkg.sv
// Shared types and constants for the NAND DQ read-capture calibration logic.
// Pure declarations: no logic, no latency, no flow control.
package nand_phy_pkg;

  localparam int TAP_W   = 5;
  localparam int WIDTH_W = 6;

  localparam logic [7:0] PATTERN_RISE_DEF = 8'hA5;
  localparam logic [7:0] PATTERN_FALL_DEF = 8'h5A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_TAP,
    ST_SETTLE,
    ST_SAMPLE,
    ST_STEP,
    ST_EVAL,
    ST_CTR_RST,
    ST_CTR_STEP,
    ST_DONE,
    ST_FAIL
  } cal_state_e;

endpackage

// File: rtl/nand_dq_eye_track.sv
// Tracks the current run of passing taps and keeps the longest one seen (earliest wins ties).
// Best start/width update one cycle after a tap_vld strobe; no backpressure.
module nand_dq_eye_track
  import nand_phy_pkg::*;
#(
  parameter int TAP_MAX = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               tap_vld,
  input  logic               tap_pass,
  input  logic [TAP_W-1:0]   tap_idx,
  output logic [TAP_W-1:0]   best_start,
  output logic [WIDTH_W-1:0] best_width
);

  localparam logic [WIDTH_W-1:0] LEN_SAT  = WIDTH_W'(TAP_MAX + 1);
  localparam logic [TAP_W-1:0]   LAST_TAP = TAP_W'(TAP_MAX);

  logic [TAP_W-1:0]   run_start_q, run_start_d, best_start_q, best_start_d, cand_start;
  logic [WIDTH_W-1:0] run_len_q, run_len_d, best_len_q, best_len_d, cand_len;
  logic               close_run;

  always_comb begin
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    cand_start   = run_start_q;
    cand_len     = run_len_q;
    close_run    = 1'b0;
    if (clr) begin
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (tap_vld) begin
      if (tap_pass) begin
        if (run_len_q == '0) begin
          cand_start = tap_idx;
          cand_len   = WIDTH_W'(1);
        end else if (run_len_q != LEN_SAT) begin
          cand_len = run_len_q + 1'b1;
        end
        run_start_d = cand_start;
        run_len_d   = cand_len;
        close_run   = (tap_idx == LAST_TAP);
      end else begin
        close_run = 1'b1;
      end
      // Strictly longer replaces, so the earliest of equal windows is kept.
      if (close_run) begin
        run_len_d = '0;
        if (cand_len > best_len_q) begin
          best_start_d = cand_start;
          best_len_d   = cand_len;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start = best_start_q;
  assign best_width = best_len_q;

endmodule

// File: rtl/nand_dq_delay_cal.sv
// DQ lane IDELAY calibration: sweep taps, score training beats, park at the centre of the best eye.
// All outputs registered; rd_valid beats are consumed the cycle they arrive (no backpressure).
module nand_dq_delay_cal
  import nand_phy_pkg::*;
#(
  parameter int                NUM_DQ         = 8,
  parameter int                TAP_MAX        = 31,
  parameter int                SETTLE_CYCLES  = 8,
  parameter int                MATCH_COUNT    = 16,
  parameter int                SAMPLE_TIMEOUT = 1024,
  parameter logic [NUM_DQ-1:0] PATTERN_RISE   = PATTERN_RISE_DEF,
  parameter logic [NUM_DQ-1:0] PATTERN_FALL   = PATTERN_FALL_DEF
) (
  input  logic               clk90,
  input  logic               rst90_n,
  input  logic               cal_start,
  input  logic               rd_valid,
  input  logic [NUM_DQ-1:0]  rd_data_rise,
  input  logic [NUM_DQ-1:0]  rd_data_fall,
  output logic               dlyrst,
  output logic               dlyce,
  output logic               dlyinc,
  output logic               cal_busy,
  output logic               cal_done,
  output logic               cal_fail,
  output logic [TAP_W-1:0]   tap_value,
  output logic [TAP_W-1:0]   eye_start,
  output logic [WIDTH_W-1:0] eye_width
);

  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int MATCH_W = $clog2(MATCH_COUNT + 1);
  localparam int TMO_W   = $clog2(SAMPLE_TIMEOUT + 1);

  localparam logic [SET_W-1:0]   SET_LAST   = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(SAMPLE_TIMEOUT - 1);
  localparam logic [TAP_W-1:0]   LAST_TAP   = TAP_W'(TAP_MAX);

  cal_state_e state_q, state_d;

  logic               dlyrst_q, dlyrst_d, dlyce_q, dlyce_d, dlyinc_q, dlyinc_d;
  logic               busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [TAP_W-1:0]   tap_q, tap_d, target_q, target_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               beat_ok, tap_vld, tap_pass, eye_clr;

  assign beat_ok = (rd_data_rise == PATTERN_RISE) && (rd_data_fall == PATTERN_FALL);

  always_ff @(posedge clk90 or negedge rst90_n) begin
    if (!rst90_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: if (cal_start) state_d = ST_RST_TAP;
      ST_RST_TAP:  state_d = ST_SETTLE;
      ST_SETTLE:   if (settle_cnt_q == SET_LAST) state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        if (rd_valid && (!beat_ok || match_cnt_q == MATCH_LAST)) state_d = ST_STEP;
        else if (tmo_cnt_q == TMO_LAST)                          state_d = ST_FAIL;
      end
      ST_STEP:     state_d = (tap_q == LAST_TAP) ? ST_EVAL : ST_SETTLE;
      ST_EVAL:     state_d = (eye_width == '0) ? ST_FAIL : ST_CTR_RST;
      ST_CTR_RST:  state_d = ST_CTR_STEP;
      ST_CTR_STEP: if (tap_q == target_q) state_d = ST_DONE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dlyrst_d     = 1'b0;
    dlyce_d      = 1'b0;
    tap_d        = tap_q;
    target_d     = target_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    settle_cnt_d = (state_q == ST_SETTLE) ? settle_cnt_q + 1'b1 : '0;
    tmo_cnt_d    = (state_q == ST_SAMPLE) ? tmo_cnt_q + 1'b1 : '0;
    match_cnt_d  = '0;
    tap_vld      = 1'b0;
    tap_pass     = 1'b0;
    eye_clr      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (cal_start) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          eye_clr = 1'b1;
        end
      end
      ST_RST_TAP, ST_CTR_RST: begin
        dlyrst_d = 1'b1;
        tap_d    = '0;
      end
      ST_SAMPLE: begin
        match_cnt_d = match_cnt_q;
        if (rd_valid) begin
          if (!beat_ok) begin
            tap_vld = 1'b1;
          end else if (match_cnt_q == MATCH_LAST) begin
            tap_vld  = 1'b1;
            tap_pass = 1'b1;
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end
      end
      ST_STEP, ST_CTR_STEP: begin
        if ((state_q == ST_STEP && tap_q != LAST_TAP) ||
            (state_q == ST_CTR_STEP && tap_q != target_q)) begin
          dlyce_d = 1'b1;
          tap_d   = tap_q + 1'b1;
        end
      end
      // start + width/2 stays within the tap range because start + width <= TAP_MAX + 1.
      ST_EVAL:  target_d = eye_start + TAP_W'(eye_width >> 1);
      default: ;
    endcase
    if (state_d == ST_FAIL && state_q != ST_FAIL) begin
      dlyrst_d = 1'b1;
      tap_d    = '0;
      fail_d   = 1'b1;
      busy_d   = 1'b0;
    end
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
    dlyinc_d = dlyce_d;
  end

  always_ff @(posedge clk90 or negedge rst90_n) begin
    if (!rst90_n) begin
      dlyrst_q     <= 1'b0;
      dlyce_q      <= 1'b0;
      dlyinc_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      tap_q        <= '0;
      target_q     <= '0;
      settle_cnt_q <= '0;
      match_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      dlyrst_q     <= dlyrst_d;
      dlyce_q      <= dlyce_d;
      dlyinc_q     <= dlyinc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      tap_q        <= tap_d;
      target_q     <= target_d;
      settle_cnt_q <= settle_cnt_d;
      match_cnt_q  <= match_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  nand_dq_eye_track #(
    .TAP_MAX (TAP_MAX)
  ) u_eye (
    .clk        (clk90),
    .rst_n      (rst90_n),
    .clr        (eye_clr),
    .tap_vld    (tap_vld),
    .tap_pass   (tap_pass),
    .tap_idx    (tap_q),
    .best_start (eye_start),
    .best_width (eye_width)
  );

  assign dlyrst    = dlyrst_q;
  assign dlyce     = dlyce_q;
  assign dlyinc    = dlyinc_q;
  assign cal_busy  = busy_q;
  assign cal_done  = done_q;
  assign cal_fail  = fail_q;
  assign tap_value = tap_q;

endmodule

// File: tb/tb_nand_dq_delay_cal.sv
// Bench for nand_dq_delay_cal: an IDELAY/channel model feeds beats whose quality depends on the
// modelled tap; results are compared against a window-scan reference and a vector table.
module tb_nand_dq_delay_cal;

  logic       clk90 = 1'b0;
  logic       rst90_n, cal_start, rd_valid;
  logic [7:0] rd_data_rise, rd_data_fall;
  logic       dlyrst, dlyce, dlyinc, cal_busy, cal_done, cal_fail;
  logic [4:0] tap_value, eye_start;
  logic [5:0] eye_width;

  always #5 clk90 = ~clk90;

  nand_dq_delay_cal dut (
    .clk90(clk90), .rst90_n(rst90_n), .cal_start(cal_start), .rd_valid(rd_valid),
    .rd_data_rise(rd_data_rise), .rd_data_fall(rd_data_fall),
    .dlyrst(dlyrst), .dlyce(dlyce), .dlyinc(dlyinc), .cal_busy(cal_busy),
    .cal_done(cal_done), .cal_fail(cal_fail), .tap_value(tap_value),
    .eye_start(eye_start), .eye_width(eye_width)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] pass_mask = '0;
  int          bad3_tap  = -1;
  bit          chan_en   = 1'b0;
  logic [4:0]  ch_tap    = '0;

  int n_rst = 0, n_ce = 0, ce_since_rst = 0, proto_err = 0;
  bit prev_busy = 0, prev_done = 0, prev_fail = 0, prev_rst = 0;

  typedef struct {
    logic [31:0] mask;
    int          bad3;
    bit          exp_done;
    int          exp_start;
    int          exp_width;
    int          exp_tap;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int t = lo; t <= hi; t++) m[t] = 1'b1;
    return m;
  endfunction

  // Reference: longest run of set bits, earliest on ties.
  function automatic void model(input logic [31:0] m, output int s, output int w);
    int cs = 0, cw = 0;
    s = 0;
    w = 0;
    for (int t = 0; t < 32; t++) begin
      if (m[t]) begin
        if (cw == 0) cs = t;
        cw++;
        if (cw > w) begin
          s = cs;
          w = cw;
        end
      end else begin
        cw = 0;
      end
    end
  endfunction

  // IDELAY tap model driven only by the pulses the DUT issues.
  initial forever begin
    @(posedge clk90);
    if (dlyrst) ch_tap = '0;
    else if (dlyce && dlyinc) ch_tap = ch_tap + 5'd1;
  end

  // Channel: correct pattern at passing taps, corrupted data elsewhere, random beat gaps.
  initial forever begin
    @(negedge clk90);
    rd_data_rise = 8'($urandom());
    rd_data_fall = 8'($urandom());
    rd_valid     = 1'b0;
    if (chan_en && $urandom_range(3, 0) != 0) begin
      rd_valid = 1'b1;
      if (pass_mask[ch_tap]) begin
        rd_data_rise = 8'hA5;
        rd_data_fall = 8'h5A;
      end else begin
        rd_data_rise = 8'hA5 ^ 8'($urandom_range(255, 1));
        rd_data_fall = 8'h5A;
      end
      if (int'(ch_tap) == bad3_tap) rd_data_rise = 8'hA5 ^ 8'h08;
    end
  end

  // Pulse bookkeeping and protocol watch.
  initial forever begin
    @(negedge clk90);
    if (dlyrst) begin
      n_rst++;
      ce_since_rst = 0;
    end
    if (dlyce) begin
      n_ce++;
      ce_since_rst++;
    end
    if (dlyinc !== dlyce) proto_err++;
    if (dlyrst && dlyce) proto_err++;
    if (dlyrst && prev_rst) proto_err++;
    if ((cal_done && !prev_done) || (cal_fail && !prev_fail))
      if (cal_busy || !prev_busy) proto_err++;
    prev_busy = cal_busy;
    prev_done = cal_done;
    prev_fail = cal_fail;
    prev_rst  = dlyrst;
  end

  task automatic start_cal();
    @(negedge clk90);
    cal_start = 1'b1;
    @(negedge clk90);
    cal_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int cyc);
    cyc = 0;
    while (!(cal_done || cal_fail) && cyc < budget) begin
      @(negedge clk90);
      cyc++;
    end
    check("wait_end_in_budget", (cyc < budget), 1);
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] mask, input int b3,
                               input bit e_done, input int e_start, input int e_width,
                               input int e_tap);
    int rst0, ce0, cyc;
    pass_mask = mask;
    bad3_tap  = b3;
    chan_en   = 1'b1;
    rst0      = n_rst;
    ce0       = n_ce;
    start_cal();
    check({tag, "_busy_rise"}, cal_busy, 1);
    wait_end(20000, cyc);
    repeat (2) @(negedge clk90);
    check({tag, "_done"}, cal_done, e_done);
    check({tag, "_fail"}, cal_fail, !e_done);
    check({tag, "_busy_low"}, cal_busy, 0);
    check({tag, "_eye_start"}, eye_start, e_start);
    check({tag, "_eye_width"}, eye_width, e_width);
    check({tag, "_tap_value"}, tap_value, e_tap);
    check({tag, "_tap_vs_idelay"}, tap_value, ch_tap);
    check({tag, "_dlyrst_count"}, n_rst - rst0, 2);
    check({tag, "_dlyce_count"}, n_ce - ce0, e_done ? 31 + e_tap : 31);
    if (e_done) check({tag, "_ce_after_ctr_rst"}, ce_since_rst, e_tap);
  endtask

  initial begin
    int s, w, cyc, rst0, ce0;
    logic [31:0] m;

    vecs[0] = '{rng(10, 20), -1, 1'b1, 10, 11, 15};
    vecs[1] = '{rng(3, 5) | rng(20, 25), -1, 1'b1, 20, 6, 23};
    vecs[2] = '{rng(2, 4) | rng(9, 11), -1, 1'b1, 2, 3, 3};
    vecs[3] = '{32'hFFFF_FFFF, -1, 1'b1, 0, 32, 16};
    vecs[4] = '{32'h0, -1, 1'b0, 0, 0, 0};
    vecs[5] = '{rng(4, 10), 7, 1'b1, 4, 3, 5};

    rst90_n   = 1'b0;
    cal_start = 1'b0;
    repeat (3) @(negedge clk90);
    check("reset_outputs", {dlyrst, dlyce, dlyinc, cal_busy, cal_done, cal_fail,
                            tap_value, eye_start, eye_width}, 0);
    rst90_n = 1'b1;
    repeat (2) @(negedge clk90);

    for (int i = 0; i < 6; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].mask, vecs[i].bad3, vecs[i].exp_done,
                    vecs[i].exp_start, vecs[i].exp_width, vecs[i].exp_tap);

    for (int r = 0; r < 6; r++) begin
      m = $urandom();
      if (r % 2 == 1) m = m | rng(r * 3, r * 3 + 6);
      if (r == 4) m = '0;
      model(m, s, w);
      run_and_check($sformatf("rand%0d", r), m, -1, (w > 0), s, w, (w > 0) ? s + w / 2 : 0);
    end

    // Dead bus: no beats at all, expect timeout failure parked at tap 0.
    chan_en = 1'b0;
    rst0 = n_rst;
    ce0  = n_ce;
    start_cal();
    wait_end(3000, cyc);
    check("tmo_cycles_in_range", (cyc >= 1024 && cyc <= 1100), 1);
    repeat (2) @(negedge clk90);
    check("tmo_fail", cal_fail, 1);
    check("tmo_done", cal_done, 0);
    check("tmo_tap", tap_value, 0);
    check("tmo_dlyce_count", n_ce - ce0, 0);
    check("tmo_dlyrst_count", n_rst - rst0, 2);

    // Reset mid-sweep at tap 12.
    pass_mask = 32'hFFFF_FFFF;
    bad3_tap  = -1;
    chan_en   = 1'b1;
    start_cal();
    cyc = 0;
    while (tap_value != 5'd12 && cyc < 3000) begin
      @(negedge clk90);
      cyc++;
    end
    check("reach_tap12", (cyc < 3000), 1);
    #2 rst90_n = 1'b0;
    #1;
    check("async_reset_outputs", {dlyrst, dlyce, dlyinc, cal_busy, cal_done, cal_fail,
                                  tap_value, eye_start, eye_width}, 0);
    @(negedge clk90);
    rst90_n = 1'b1;
    @(negedge clk90);

    // Restart must begin with a tap reset; a cal_start while busy is ignored.
    pass_mask = rng(10, 20);
    rst0 = n_rst;
    start_cal();
    cyc = 0;
    while (!(dlyrst || dlyce) && cyc < 50) begin
      @(negedge clk90);
      cyc++;
    end
    check("restart_first_pulse_is_dlyrst", {dlyrst, dlyce}, 2'b10);
    cyc = 0;
    while (tap_value != 5'd5 && cyc < 3000) begin
      @(negedge clk90);
      cyc++;
    end
    start_cal();
    wait_end(20000, cyc);
    repeat (2) @(negedge clk90);
    check("busy_start_dlyrst_count", n_rst - rst0, 2);
    check("busy_start_done", cal_done, 1);
    check("busy_start_eye_start", eye_start, 10);
    check("busy_start_eye_width", eye_width, 11);
    check("busy_start_tap", tap_value, 15);

    check("protocol_errors", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
